// File: rtl/qc_ldpc_pkg.sv
// Shared types and sizing for the QC-LDPC shift scheduler.
//   MAXZ / NB_ROWS / NB_COLS fix the tag and address widths.
//   DEF_* values are the defaults for the scheduler's per-instance parameters.
package qc_ldpc_pkg;

  localparam int unsigned MAXZ              = 81;
  localparam int unsigned NB_ROWS           = 12;
  localparam int unsigned NB_COLS           = 24;
  localparam int unsigned DEF_SHIFT_LATENCY = 10;
  localparam int unsigned DEF_CREDITS       = 4;

  localparam int unsigned SHIFT_W = $clog2(MAXZ);
  localparam int unsigned ENTRY_W = SHIFT_W + 1;
  localparam int unsigned ROW_W   = $clog2(NB_ROWS);
  localparam int unsigned COL_W   = $clog2(NB_COLS);
  localparam int unsigned ADDR_W  = $clog2(NB_ROWS * NB_COLS);

  // All-ones (-1) marks an empty base-matrix position.
  localparam logic [ENTRY_W-1:0] NULL_ENTRY = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_EVAL  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             row_end;
  } shift_tag_t;

  // Signed entry is a legal shift when 0 <= e < MAXZ.
  function automatic logic entry_in_range(input logic [ENTRY_W-1:0] e);
    return !e[ENTRY_W-1] && (e[SHIFT_W-1:0] < SHIFT_W'(MAXZ));
  endfunction

endpackage

// File: rtl/qc_tag_delay.sv
// Fixed-depth delay line for shifter tags, aligning them with shifter output.
//   clk, rst_n   : clock, async active-low reset (clears every stage)
//   tag_i        : tag entering this cycle
//   tag_o        : tag from DEPTH cycles earlier
//   any_valid_o  : some stage still carries a valid or row_end tag
module qc_tag_delay
  import qc_ldpc_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_SHIFT_LATENCY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  shift_tag_t tag_i,
  output shift_tag_t tag_o,
  output logic       any_valid_o
);

  shift_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

  // row_end counts as occupancy so a pass is not reported done before its last row marker.
  always_comb begin
    any_valid_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid_o = any_valid_o | stage_q[i].valid | stage_q[i].row_end;
    end
  end

endmodule

// File: rtl/qc_shift_scheduler.sv
// Walks the QC-LDPC base matrix row-major and issues credit-gated rotate
// requests to a pipelined circular shifter, with tags delayed to its output.
//   CLK, rst_n            : clock, async active-low reset
//   start                 : begin a full pass (IDLE only)
//   busy, done            : pass in progress / 1-cycle completion pulse
//   bm_rd_en, bm_addr     : base-matrix read (data returns next cycle on bm_data)
//   sh_issue, sh_shift_val: shifter request and rotate amount (held when idle)
//   res_valid/row/col/row_end : tag aligned with shifter output
//   credit_ret            : consumer frees one result slot
//   err                   : sticky bad-entry / credit-overflow flag
module qc_shift_scheduler
  import qc_ldpc_pkg::*;
#(
  parameter int unsigned SHIFT_LATENCY = DEF_SHIFT_LATENCY,
  parameter int unsigned CREDITS       = DEF_CREDITS
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               bm_rd_en,
  output logic [ADDR_W-1:0]  bm_addr,
  input  logic [ENTRY_W-1:0] bm_data,
  output logic               sh_issue,
  output logic [SHIFT_W-1:0] sh_shift_val,
  output logic               res_valid,
  output logic [ROW_W-1:0]   res_row,
  output logic [COL_W-1:0]   res_col,
  output logic               res_row_end,
  input  logic               credit_ret,
  output logic               err
);

  localparam int unsigned CRED_W = $clog2(CREDITS + 1);

  sched_state_e       state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [CRED_W-1:0]  credit_q, credit_d;
  logic               err_q, err_d;
  logic [ENTRY_W-1:0] entry_q;
  logic               first_q;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               issue_q;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  shift_tag_t         tag_q, tag_d, tag_out;
  logic               pipe_any;

  logic [ENTRY_W-1:0] entry_cur;
  logic               is_null_c, in_range_c, issue_c, advance_c;
  logic               last_col_c, last_row_c, pipe_busy_c;

  // Memory data is live only in the first EVAL cycle; stalled cycles use the captured copy.
  assign entry_cur   = first_q ? bm_data : entry_q;
  assign is_null_c   = (entry_cur == NULL_ENTRY);
  assign in_range_c  = entry_in_range(entry_cur);
  assign issue_c     = (state_q == S_EVAL) && in_range_c && (credit_q != '0);
  assign advance_c   = (state_q == S_EVAL) && !(in_range_c && (credit_q == '0));
  assign last_col_c  = (col_q == COL_W'(NB_COLS - 1));
  assign last_row_c  = (row_q == ROW_W'(NB_ROWS - 1));
  assign pipe_busy_c = pipe_any || tag_q.valid || tag_q.row_end;

  // State register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RD;
      S_RD:    state_d = S_EVAL;
      S_EVAL:  if (advance_c) state_d = (last_row_c && last_col_c) ? S_DRAIN : S_RD;
      S_DRAIN: if (!pipe_busy_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values (outputs registered against the next state)
  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    err_d    = err_q;
    credit_d = credit_q;
    shift_d  = shift_q;
    tag_d    = '0;
    addr_d   = addr_q;
    busy_d   = (state_d == S_RD) || (state_d == S_EVAL) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
    rd_en_d  = (state_d == S_RD);

    if ((state_q == S_IDLE) && start) begin
      err_d = 1'b0;
      row_d = '0;
      col_d = '0;
    end

    if (issue_c) shift_d = entry_cur[SHIFT_W-1:0];

    if (advance_c) begin
      tag_d.valid   = issue_c;
      tag_d.row     = row_q;
      tag_d.col     = col_q;
      tag_d.row_end = last_col_c;
      if (!is_null_c && !in_range_c) err_d = 1'b1;
      if (last_col_c) begin
        col_d = '0;
        row_d = last_row_c ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (rd_en_d) addr_d = ADDR_W'(ADDR_W'(row_d) * ADDR_W'(NB_COLS)) + ADDR_W'(col_d);

    // Counter tracks the visible sh_issue so an issue and a return in one cycle cancel.
    case ({issue_q, credit_ret})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CRED_W'(CREDITS)) err_d = 1'b1;
        else                              credit_d = credit_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      col_q    <= '0;
      credit_q <= CRED_W'(CREDITS);
      err_q    <= 1'b0;
      entry_q  <= '0;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      issue_q  <= 1'b0;
      shift_q  <= '0;
      tag_q    <= '0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      entry_q  <= entry_cur;
      first_q  <= (state_q == S_RD);
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      issue_q  <= issue_c;
      shift_q  <= shift_d;
      tag_q    <= tag_d;
    end
  end

  // tag_q is aligned with sh_issue; the delay line adds the shifter latency.
  qc_tag_delay #(
    .DEPTH (SHIFT_LATENCY)
  ) u_tag_delay (
    .clk         (CLK),
    .rst_n       (rst_n),
    .tag_i       (tag_q),
    .tag_o       (tag_out),
    .any_valid_o (pipe_any)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign bm_rd_en     = rd_en_q;
  assign bm_addr      = addr_q;
  assign sh_issue     = issue_q;
  assign sh_shift_val = shift_q;
  assign err          = err_q;
  assign res_valid    = tag_out.valid;
  assign res_row      = tag_out.row;
  assign res_col      = tag_out.col;
  assign res_row_end  = tag_out.row_end;

endmodule

// File: tb/tb_qc_shift_scheduler.sv
// Directed bench for qc_shift_scheduler with a synchronous base-matrix model.
module tb_qc_shift_scheduler;
  import qc_ldpc_pkg::*;

  localparam int unsigned DEPTH = NB_ROWS * NB_COLS;

  logic               CLK;
  logic               rst_n;
  logic               start;
  logic               busy, done, bm_rd_en;
  logic [ADDR_W-1:0]  bm_addr;
  logic [ENTRY_W-1:0] bm_data;
  logic               sh_issue;
  logic [SHIFT_W-1:0] sh_shift_val;
  logic               res_valid;
  logic [ROW_W-1:0]   res_row;
  logic [COL_W-1:0]   res_col;
  logic               res_row_end;
  logic               credit_ret;
  logic               err;
  logic [31:0]        out_vec;

  logic [ENTRY_W-1:0] mem [DEPTH];

  int n_checks, n_fail;
  int cyc, n_issue, n_res, n_rowend, n_done, issue_cyc, res_cyc, last_row, last_col;
  int shift_log [16];
  bit auto_ret;

  qc_shift_scheduler dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .bm_rd_en     (bm_rd_en),
    .bm_addr      (bm_addr),
    .bm_data      (bm_data),
    .sh_issue     (sh_issue),
    .sh_shift_val (sh_shift_val),
    .res_valid    (res_valid),
    .res_row      (res_row),
    .res_col      (res_col),
    .res_row_end  (res_row_end),
    .credit_ret   (credit_ret),
    .err          (err)
  );

  assign out_vec = {busy, done, bm_rd_en, bm_addr, sh_issue, sh_shift_val,
                    res_valid, res_row, res_col, res_row_end, err};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous base-matrix memory: one cycle read latency.
  always @(posedge CLK) begin
    if (bm_rd_en) bm_data <= mem[bm_addr];
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    n_issue = 0; n_res = 0; n_rowend = 0; n_done = 0;
    issue_cyc = -1; res_cyc = -1; last_row = -1; last_col = -1;
    for (int i = 0; i < 16; i++) shift_log[i] = -1;
  endtask

  task automatic set_null();
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = NULL_ENTRY;
  endtask

  // Advance one clock and sample outputs 1 ns after the rising edge.
  task automatic sample_cycle();
    @(posedge CLK);
    #1;
    cyc++;
    if (sh_issue) begin
      if (n_issue < 16) shift_log[n_issue] = int'(sh_shift_val);
      if (n_issue == 0) issue_cyc = cyc;
      n_issue++;
    end
    if (res_valid) begin
      if (n_res == 0) res_cyc = cyc;
      n_res++;
      last_row = int'(res_row);
      last_col = int'(res_col);
    end
    if (res_row_end) n_rowend++;
    if (done) n_done++;
    if (auto_ret) credit_ret = res_valid;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) sample_cycle();
  endtask

  task automatic run_to_done(input string tag, input int budget, input int tail);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      sample_cycle();
      k++;
    end
    check_eq(tag, int'(n_done != 0), 1);
    run_cycles(tail);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sample_cycle();
    start = 1'b0;
  endtask

  task automatic return_credits(input int n);
    credit_ret = 1'b1;
    run_cycles(n);
    credit_ret = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; credit_ret = 1'b0; auto_ret = 1'b0;
    bm_data = '0;
    clr_mon();
    set_null();

    // 1: reset, then start
    run_cycles(5);
    check_eq("rst_outputs", int'(out_vec), 0);
    rst_n = 1'b1;
    sample_cycle();
    check_eq("idle_busy", int'(busy), 0);

    // 2: single valid entry at (r0,c3)
    set_null();
    mem[3] = ENTRY_W'(5);
    clr_mon();
    auto_ret = 1'b1;
    pulse_start();
    check_eq("start_busy", int'(busy), 1);
    check_eq("start_rd_en", int'(bm_rd_en), 1);
    check_eq("start_addr", int'(bm_addr), 0);
    run_cycles(2);
    check_eq("second_addr", int'(bm_addr), 1);
    run_to_done("t2_done_seen", 1000, 15);
    auto_ret = 1'b0; credit_ret = 1'b0;
    check_eq("t2_n_issue", n_issue, 1);
    check_eq("t2_shift", shift_log[0], 5);
    check_eq("t2_latency", res_cyc - issue_cyc, 10);
    check_eq("t2_n_res", n_res, 1);
    check_eq("t2_res_row", last_row, 0);
    check_eq("t2_res_col", last_col, 3);
    check_eq("t2_row_end", n_rowend, 12);
    check_eq("t2_n_done", n_done, 1);
    check_eq("t2_err", int'(err), 0);
    check_eq("t2_busy_end", int'(busy), 0);

    // 3: five valid entries, no returns: the fifth stalls on zero credits
    set_null();
    for (int i = 0; i < 5; i++) mem[i] = ENTRY_W'(i + 1);
    clr_mon();
    pulse_start();
    run_cycles(40);
    check_eq("t3_stall_issues", n_issue, 4);
    check_eq("t3_stall_res", n_res, 4);
    check_eq("t3_stall_busy", int'(busy), 1);
    check_eq("t3_stall_rd_en", int'(bm_rd_en), 0);
    check_eq("t3_stall_addr", int'(bm_addr), 4);
    credit_ret = 1'b1;
    sample_cycle();
    credit_ret = 1'b0;
    check_eq("t3_ret_cycle_issue", int'(sh_issue), 0);
    sample_cycle();
    check_eq("t3_release_issue", int'(sh_issue), 1);
    check_eq("t3_release_shift", int'(sh_shift_val), 5);
    run_to_done("t3_done_seen", 1000, 15);
    check_eq("t3_n_issue", n_issue, 5);
    check_eq("t3_err", int'(err), 0);
    return_credits(4);
    check_eq("t3_refill_err", int'(err), 0);
    return_credits(1);
    check_eq("t3_overflow_err", int'(err), 1);

    // 4: credit_ret coincident with sh_issue at one credit
    set_null();
    for (int i = 0; i < 6; i++) mem[i] = ENTRY_W'(10 + i);
    clr_mon();
    pulse_start();
    check_eq("t4_start_clears_err", int'(err), 0);
    for (int i = 0; i < 40; i++) begin
      sample_cycle();
      credit_ret = sh_issue && (n_issue == 4);
    end
    credit_ret = 1'b0;
    check_eq("t4_issues_before_stall", n_issue, 5);
    check_eq("t4_err", int'(err), 0);
    check_eq("t4_stalled", int'(bm_rd_en), 0);
    check_eq("t4_shift4", shift_log[4], 14);
    return_credits(1);
    run_to_done("t4_done_seen", 1000, 15);
    check_eq("t4_n_issue", n_issue, 6);
    check_eq("t4_shift5", shift_log[5], 15);
    return_credits(4);
    check_eq("t4_refill_err", int'(err), 0);

    // 5: out-of-range entries 81 and -2, boundary values 80 and 0
    set_null();
    mem[0] = ENTRY_W'(81);
    mem[1] = ENTRY_W'(8'hFE);
    mem[2] = ENTRY_W'(80);
    mem[3] = ENTRY_W'(0);
    clr_mon();
    auto_ret = 1'b1;
    pulse_start();
    run_cycles(2);
    check_eq("t5_err_81", int'(err), 1);
    check_eq("t5_no_issue_81", int'(sh_issue), 0);
    run_to_done("t5_done_seen", 1000, 15);
    auto_ret = 1'b0; credit_ret = 1'b0;
    check_eq("t5_n_issue", n_issue, 2);
    check_eq("t5_shift_80", shift_log[0], 80);
    check_eq("t5_shift_0", shift_log[1], 0);
    check_eq("t5_n_done", n_done, 1);
    check_eq("t5_err_sticky", int'(err), 1);

    // 6: reset with three requests in flight, then a clean pass
    set_null();
    for (int i = 0; i < 3; i++) mem[i] = ENTRY_W'(20 + i);
    clr_mon();
    pulse_start();
    run_cycles(7);
    check_eq("t6_inflight_issues", n_issue, 3);
    check_eq("t6_inflight_res", n_res, 0);
    rst_n = 1'b0;
    run_cycles(3);
    check_eq("t6_rst_outputs", int'(out_vec), 0);
    rst_n = 1'b1;
    clr_mon();
    run_cycles(30);
    check_eq("t6_no_res_after_rst", n_res, 0);
    check_eq("t6_idle_busy", int'(busy), 0);
    set_null();
    mem[0] = ENTRY_W'(1);
    mem[DEPTH-1] = ENTRY_W'(9);
    clr_mon();
    auto_ret = 1'b1;
    pulse_start();
    run_to_done("t6_done_seen", 1000, 15);
    auto_ret = 1'b0; credit_ret = 1'b0;
    check_eq("t6_n_issue", n_issue, 2);
    check_eq("t6_n_res", n_res, 2);
    check_eq("t6_shift_last", shift_log[1], 9);
    check_eq("t6_last_row", last_row, 11);
    check_eq("t6_last_col", last_col, 23);
    check_eq("t6_row_end", n_rowend, 12);
    check_eq("t6_err", int'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
